// File: rtl/cuppa_spi_pkg.sv
// Shared constants and state encoding for the digitizer SPI master.
package cuppa_spi_pkg;

  localparam int CMD_W  = 16;
  localparam int RD_W   = 8;
  localparam int RW_BIT = 15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAIT_LOW = 3'd5
  } spi_state_t;

endpackage

// File: rtl/cuppa_spi_tick_gen.sv
// SCLK half-period down-counter; tick marks the last clk cycle of a phase.
module cuppa_spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= RELOAD;
    end else if (en) begin
      if (cnt == '0) cnt <= RELOAD;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/cuppa_dig_spi_master.sv
// Mode-0 SPI master answering the digitizer req/ack handshake: 16-bit command out,
// 8-bit read-back captured from the last 8 SCLK periods of a read.
//
// state    | meaning
// IDLE     | waiting for spi_req
// SETUP    | cs_n low, first MOSI bit presented, CS_SETUP cycles
// SHIFT    | 16 SCLK periods, MISO sampled at end of each high phase
// HOLD     | SCLK idle low, cs_n still low, CS_HOLD cycles
// ACK      | cs_n released, one-cycle spi_ack, read data committed
// WAIT_LOW | waiting for spi_req to drop so a held request cannot retrigger
module cuppa_dig_spi_master
  import cuppa_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int SEL_W    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_req,
  output logic                  spi_ack,
  input  logic [SEL_W-1:0]      spi_sel,
  input  logic [CMD_W-1:0]      spi_wr_data,
  output logic [RD_W-1:0]       spi_rd_data,
  output logic                  busy,
  output logic                  sclk,
  output logic [2**SEL_W-1:0]   cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int N_CS    = 2**SEL_W;
  localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TW      = $clog2(TMR_MAX + 1);

  spi_state_t       state, state_nxt;
  logic [CMD_W-1:0] tx_shift;
  logic [RD_W-1:0]  rd_shift;
  logic [RD_W-1:0]  rd_data_q;
  logic [SEL_W-1:0] sel_q;
  logic             rw_q;
  logic [3:0]       bit_cnt;
  logic [TW-1:0]    tmr;
  logic             phase_high;
  logic             tick;
  logic             last_edge;

  cuppa_spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != ST_SHIFT),
    .en   (state == ST_SHIFT),
    .tick (tick)
  );

  // End of a high phase: the edge that drops SCLK, samples MISO and advances MOSI.
  assign last_edge = tick && phase_high;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (spi_req) state_nxt = ST_SETUP;
      ST_SETUP:    if (tmr == '0) state_nxt = ST_SHIFT;
      ST_SHIFT:    if (last_edge && (bit_cnt == 4'd0)) state_nxt = ST_HOLD;
      ST_HOLD:     if (tmr == '0) state_nxt = ST_ACK;
      ST_ACK:      state_nxt = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!spi_req) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift   <= '0;
      rd_shift   <= '0;
      rd_data_q  <= '0;
      sel_q      <= '0;
      rw_q       <= 1'b0;
      bit_cnt    <= '0;
      tmr        <= '0;
      phase_high <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (spi_req) begin
            tx_shift   <= spi_wr_data;
            rw_q       <= spi_wr_data[RW_BIT];
            sel_q      <= spi_sel;
            tmr        <= TW'(CS_SETUP - 1);
            bit_cnt    <= 4'd15;
            phase_high <= 1'b0;
          end
        end
        ST_SETUP: if (tmr != '0) tmr <= tmr - 1'b1;
        ST_SHIFT: begin
          if (tick) phase_high <= ~phase_high;
          if (last_edge) begin
            rd_shift <= {rd_shift[RD_W-2:0], miso};
            tx_shift <= {tx_shift[CMD_W-2:0], 1'b0};
            bit_cnt  <= bit_cnt - 1'b1;
            if (bit_cnt == 4'd0) tmr <= TW'(CS_HOLD - 1);
          end
        end
        ST_HOLD: if (tmr != '0) tmr <= tmr - 1'b1;
        ST_ACK:  if (rw_q) rd_data_q <= rd_shift;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (state == ST_SETUP) || (state == ST_SHIFT) ||
              (state == ST_HOLD)  || (state == ST_ACK);
    spi_ack = (state == ST_ACK);
    sclk    = (state == ST_SHIFT) && phase_high;
    mosi    = ((state == ST_SETUP) || (state == ST_SHIFT)) ? tx_shift[CMD_W-1] : 1'b0;
    cs_n    = {N_CS{1'b1}};
    if ((state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD))
      cs_n[sel_q] = 1'b0;
  end

  assign spi_rd_data = rd_data_q;

endmodule
